// File: rtl/bcd_seg7_scan.sv
// Time-multiplexed common-anode 7-segment driver with frame-boundary double buffering.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module bcd_seg7_scan #(
  parameter int DIGITS       = 2,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS*4-1:0]   bcd,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;

  // load is a single-cycle strobe with no back-pressure: bcd is captured into
  // the pending buffer on every rising edge where load is high.

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DIGITS*4-1:0]   r_pending;
  logic [DIGITS*4-1:0]   r_display;
  logic [6:0]            r_seg;
  logic [DIGITS-1:0]     r_an;
  logic                  r_frame_done;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic                  w_in_blank;
  logic [3:0]            w_digit;
  logic                  w_digit_blank;
  logic [DIGITS-1:0]     w_lz_mask;
  logic                  w_all_zero;
  logic [6:0]            w_seg_next;
  logic [DIGITS-1:0]     w_an_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
  assign w_in_blank  = (32'(r_cnt) < BLANK_CYCLES);

  always_comb begin
    w_digit = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) w_digit = r_display[4*k +: 4];
    end
  end

  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    w_lz_mask  = '0;
    w_all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_all_zero   = w_all_zero & (r_display[4*k +: 4] == 4'd0);
      w_lz_mask[k] = w_all_zero;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    w_digit_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) w_digit_blank = w_lz_mask[k];
    end
  end
`else
  assign w_digit_blank = 1'b0;
`endif

  always_comb begin
    w_seg_next = SEG_OFF;
    w_an_next  = '1;
    if (!w_in_blank) begin
      w_an_next  = ~(DIGITS'(1) << r_idx);
      w_seg_next = w_digit_blank ? SEG_OFF : decode(w_digit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A load landing on the frame edge bypasses pending so it is not lost for a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_display <= '0;
    end else begin
      if (load) r_pending <= bcd;
      if (w_frame_end) r_display <= load ? bcd : r_pending;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= SEG_OFF;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_next;
      r_an         <= w_an_next;
      r_frame_done <= w_frame_end;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Directed bench for bcd_seg7_scan with DIGITS=2, SCAN_DIV=8, BLANK_CYCLES=2.
// Outputs after edge n reflect the scan state before it: frame boundary on edges 16,32,...
module tb_bcd_seg7_scan;

  logic       clk;
  logic       rst_n;
  logic [7:0] bcd;
  logic       load;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_done;

  int checks;
  int errors;
  int e;
  int fd_cnt;

  bcd_seg7_scan #(
    .DIGITS      (2),
    .SCAN_DIV    (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd       (bcd),
    .load      (load),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    e++;
    #1;
  endtask

  task automatic goto(input int target);
    while (e < target) step();
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_at(input int edge_n, input logic [7:0] val);
    goto(edge_n - 1);
    bcd  = val;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    e      = 0;
    fd_cnt = 0;
    rst_n  = 1'b0;
    load   = 1'b0;
    bcd    = 8'h00;

    // 1. reset
    #12;
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_an", {6'd0, an}, 8'h03);
    chk("rst_fd", {7'd0, frame_done}, 8'h00);
    reset_release();
    goto(3);
    chk("f0_d0_seg", {1'b0, seg}, 8'h40);
    chk("f0_d0_an", {6'd0, an}, 8'h02);
    goto(16);
    chk("fd_first", {7'd0, frame_done}, 8'h01);
    step();
    chk("fd_drop", {7'd0, frame_done}, 8'h00);
    goto(19);
    chk("f1_d0_seg", {1'b0, seg}, 8'h40);
    chk("f1_d0_an", {6'd0, an}, 8'h02);

    // 2. basic display of 42
    load_at(20, 8'h42);
    goto(32);
    chk("fd_f2", {7'd0, frame_done}, 8'h01);
    step();
    chk("blank0_seg", {1'b0, seg}, 8'h7F);
    chk("blank0_an", {6'd0, an}, 8'h03);
    step();
    chk("blank1_seg", {1'b0, seg}, 8'h7F);
    chk("blank1_an", {6'd0, an}, 8'h03);
    step();
    chk("d0_2_seg", {1'b0, seg}, 8'h24);
    chk("d0_2_an", {6'd0, an}, 8'h02);

    // 3. mid-frame load of 97 must not tear the current frame
    load_at(37, 8'h97);
    goto(41);
    chk("d1_blank_seg", {1'b0, seg}, 8'h7F);
    chk("d1_blank_an", {6'd0, an}, 8'h03);
    goto(43);
    chk("d1_4_seg", {1'b0, seg}, 8'h19);
    chk("d1_4_an", {6'd0, an}, 8'h01);
    goto(51);
    chk("d0_7_seg", {1'b0, seg}, 8'h78);
    chk("d0_7_an", {6'd0, an}, 8'h02);
    goto(59);
    chk("d1_9_seg", {1'b0, seg}, 8'h10);
    chk("d1_9_an", {6'd0, an}, 8'h01);

    // 4. load exactly on the boundary edge bypasses into display
    load_at(64, 8'h55);
    chk("fd_bypass", {7'd0, frame_done}, 8'h01);
    goto(67);
    chk("d0_5_seg", {1'b0, seg}, 8'h12);
    chk("d0_5_an", {6'd0, an}, 8'h02);
    goto(75);
    chk("d1_5_seg", {1'b0, seg}, 8'h12);
    chk("d1_5_an", {6'd0, an}, 8'h01);
    for (int i = 76; i <= 96; i++) begin
      step();
      if (frame_done) fd_cnt++;
    end
    chk("fd_count_76_96", 8'(fd_cnt), 8'd2);

    // 5. invalid nibble, then asynchronous reset mid-slot
    load_at(97, 8'h3A);
    goto(115);
    chk("d0_A_seg", {1'b0, seg}, 8'h7F);
    chk("d0_A_an", {6'd0, an}, 8'h02);
    goto(123);
    chk("d1_3_seg", {1'b0, seg}, 8'h30);
    chk("d1_3_an", {6'd0, an}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_seg", {1'b0, seg}, 8'h7F);
    chk("async_an", {6'd0, an}, 8'h03);
    chk("async_fd", {7'd0, frame_done}, 8'h00);
    reset_release();
    goto(3);
    chk("post_rst_d0_seg", {1'b0, seg}, 8'h40);
    chk("post_rst_d0_an", {6'd0, an}, 8'h02);

    // 6. leading-zero behaviour
    goto(11);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz00_init_d1", {1'b0, seg}, 8'h7F);
`else
    chk("lz00_init_d1", {1'b0, seg}, 8'h40);
`endif
    chk("lz00_init_an", {6'd0, an}, 8'h01);
    load_at(12, 8'h07);
    goto(19);
    chk("lz07_d0", {1'b0, seg}, 8'h78);
    goto(27);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz07_d1", {1'b0, seg}, 8'h7F);
`else
    chk("lz07_d1", {1'b0, seg}, 8'h40);
`endif
    chk("lz07_d1_an", {6'd0, an}, 8'h01);
    load_at(28, 8'h00);
    goto(35);
    chk("lz00_d0", {1'b0, seg}, 8'h40);
    chk("lz00_d0_an", {6'd0, an}, 8'h02);
    goto(43);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz00_d1", {1'b0, seg}, 8'h7F);
`else
    chk("lz00_d1", {1'b0, seg}, 8'h40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
